// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes MIPS ALU-class instructions and holds them in a 2-entry skid buffer.
// Optional: define ALU_VAR_SHIFT_EN to decode sllv/srlv/srav; otherwise they decode as illegal.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_control,
  output logic [31:0] opr1,
  output logic [31:0] opr2,
  output logic [4:0]  wb_addr,
  output logic        ovf_check,
  output logic        illegal
);

  typedef struct packed {
    logic [3:0]  alu_control;
    logic [31:0] opr1;
    logic [31:0] opr2;
    logic [4:0]  wb_addr;
    logic        ovf_check;
    logic        illegal;
  } bundle_t;

  bundle_t     dec_s;
  bundle_t     main_r;
  bundle_t     skid_r;
  logic        main_valid_r;
  logic        skid_valid_r;
  logic        in_fire_s;
  logic        out_fire_s;

  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic [31:0] sext_s;
  logic [31:0] zext_s;

  assign op_s    = instr[31:26];
  assign funct_s = instr[5:0];
  assign sext_s  = {{16{instr[15]}}, instr[15:0]};
  assign zext_s  = {16'h0000, instr[15:0]};

  // Instruction decode; the defaults describe the illegal-instruction bundle.
  always_comb begin
    dec_s             = '0;
    dec_s.alu_control = 4'b0001;
    dec_s.illegal     = 1'b1;
    case (op_s)
      6'h00: begin
        case (funct_s)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            dec_s.illegal   = 1'b0;
            dec_s.opr1      = rs_data;
            dec_s.opr2      = rt_data;
            dec_s.wb_addr   = instr[15:11];
            dec_s.ovf_check = (funct_s == 6'h20) || (funct_s == 6'h22);
            case (funct_s)
              6'h20:   dec_s.alu_control = 4'b0000;
              6'h21:   dec_s.alu_control = 4'b0001;
              6'h22:   dec_s.alu_control = 4'b0010;
              6'h23:   dec_s.alu_control = 4'b0011;
              6'h24:   dec_s.alu_control = 4'b0100;
              6'h25:   dec_s.alu_control = 4'b0101;
              6'h26:   dec_s.alu_control = 4'b0110;
              6'h27:   dec_s.alu_control = 4'b0111;
              6'h2A:   dec_s.alu_control = 4'b1010;
              default: dec_s.alu_control = 4'b1011;
            endcase
          end
          6'h00, 6'h02, 6'h03: begin
            dec_s.illegal     = 1'b0;
            dec_s.opr1        = {27'd0, instr[10:6]};
            dec_s.opr2        = rt_data;
            dec_s.wb_addr     = instr[15:11];
            dec_s.alu_control = (funct_s == 6'h00) ? 4'b1111 :
                                (funct_s == 6'h02) ? 4'b1101 : 4'b1100;
          end
`ifdef ALU_VAR_SHIFT_EN
          6'h04, 6'h06, 6'h07: begin
            dec_s.illegal     = 1'b0;
            dec_s.opr1        = {27'd0, rs_data[4:0]};
            dec_s.opr2        = rt_data;
            dec_s.wb_addr     = instr[15:11];
            dec_s.alu_control = (funct_s == 6'h04) ? 4'b1111 :
                                (funct_s == 6'h06) ? 4'b1101 : 4'b1100;
          end
`endif
          default: dec_s.illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dec_s.illegal   = 1'b0;
        dec_s.opr1      = rs_data;
        dec_s.wb_addr   = instr[20:16];
        dec_s.ovf_check = (op_s == 6'h08);
        dec_s.opr2      = (op_s < 6'h0C) ? sext_s : zext_s;
        case (op_s)
          6'h08:   dec_s.alu_control = 4'b0000;
          6'h09:   dec_s.alu_control = 4'b0001;
          6'h0A:   dec_s.alu_control = 4'b1010;
          6'h0B:   dec_s.alu_control = 4'b1011;
          6'h0C:   dec_s.alu_control = 4'b0100;
          6'h0D:   dec_s.alu_control = 4'b0101;
          6'h0E:   dec_s.alu_control = 4'b0110;
          default: begin
            dec_s.alu_control = 4'b1110;
            dec_s.opr1        = 32'd0;
          end
        endcase
      end
      default: dec_s.illegal = 1'b1;
    endcase
  end

  assign in_ready   = !skid_valid_r;
  assign in_fire_s  = in_valid && !skid_valid_r;
  assign out_fire_s = main_valid_r && out_ready;

  // Main/skid storage: main drives the outputs, skid catches the bundle accepted while main stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      main_r       <= '0;
      skid_r       <= '0;
    end else if (flush) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (skid_valid_r) begin
      if (out_fire_s) begin
        main_r       <= skid_r;
        skid_valid_r <= 1'b0;
      end
    end else if (in_fire_s) begin
      if (!main_valid_r || out_fire_s) begin
        main_r       <= dec_s;
        main_valid_r <= 1'b1;
      end else begin
        skid_r       <= dec_s;
        skid_valid_r <= 1'b1;
      end
    end else if (out_fire_s) begin
      main_valid_r <= 1'b0;
    end
  end

  assign out_valid   = main_valid_r;
  assign alu_control = main_r.alu_control;
  assign opr1        = main_r.opr1;
  assign opr2        = main_r.opr2;
  assign wb_addr     = main_r.wb_addr;
  assign ovf_check   = main_r.ovf_check;
  assign illegal     = main_r.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed, table-driven bench for alu_issue_stage plus hand-written stall/flush/reset sequences.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_control;
  logic [31:0] opr1;
  logic [31:0] opr2;
  logic [4:0]  wb_addr;
  logic        ovf_check;
  logic        illegal;

  int tests = 0;
  int fails = 0;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .opr1(opr1), .opr2(opr2),
    .wb_addr(wb_addr), .ovf_check(ovf_check), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  ctrl;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [4:0]  wb;
    logic        ovf;
    logic        ill;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input int i);
    chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
    chk($sformatf("v%0d alu_control", i), {28'd0, alu_control}, {28'd0, vecs[i].ctrl});
    chk($sformatf("v%0d opr1", i), opr1, vecs[i].o1);
    chk($sformatf("v%0d opr2", i), opr2, vecs[i].o2);
    chk($sformatf("v%0d wb_addr", i), {27'd0, wb_addr}, {27'd0, vecs[i].wb});
    chk($sformatf("v%0d ovf_check", i), {31'd0, ovf_check}, {31'd0, vecs[i].ovf});
    chk($sformatf("v%0d illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
  endtask

  function automatic logic [31:0] addiu_i(input logic [4:0] rt);
    return {6'h09, 5'd0, rt, 11'd0, rt};
  endfunction

  initial begin
    vecs[0]  = '{32'h2008FFFF, 32'h0, 32'h0, 4'b0000, 32'h0, 32'hFFFFFFFF, 5'd8, 1'b1, 1'b0};
    vecs[1]  = '{32'h000A4900, 32'h0, 32'h3, 4'b1111, 32'h4, 32'h3, 5'd9, 1'b0, 1'b0};
    vecs[2]  = '{32'h3C081234, 32'h55, 32'h0, 4'b1110, 32'h0, 32'h00001234, 5'd8, 1'b0, 1'b0};
    vecs[3]  = '{32'h3108FFFF, 32'h12345678, 32'h0, 4'b0100, 32'h12345678, 32'h0000FFFF, 5'd8, 1'b0, 1'b0};
    vecs[4]  = '{32'hFC000000, 32'h5, 32'h6, 4'b0001, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};
`ifdef ALU_VAR_SHIFT_EN
    vecs[5]  = '{32'h00885007, 32'h27, 32'h80000000, 4'b1100, 32'h7, 32'h80000000, 5'd10, 1'b0, 1'b0};
`else
    vecs[5]  = '{32'h00885007, 32'h27, 32'h80000000, 4'b0001, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};
`endif
    vecs[6]  = '{32'h01095020, 32'h7, 32'h9, 4'b0000, 32'h7, 32'h9, 5'd10, 1'b1, 1'b0};
    vecs[7]  = '{32'h01095022, 32'h7, 32'h9, 4'b0010, 32'h7, 32'h9, 5'd10, 1'b1, 1'b0};
    vecs[8]  = '{32'h01095023, 32'hA, 32'hB, 4'b0011, 32'hA, 32'hB, 5'd10, 1'b0, 1'b0};
    vecs[9]  = '{32'h0109502B, 32'hC, 32'hD, 4'b1011, 32'hC, 32'hD, 5'd10, 1'b0, 1'b0};
    vecs[10] = '{32'h2908FFF0, 32'h11, 32'h0, 4'b1010, 32'h11, 32'hFFFFFFF0, 5'd8, 1'b0, 1'b0};
    vecs[11] = '{32'h350800FF, 32'h22, 32'h0, 4'b0101, 32'h22, 32'h000000FF, 5'd8, 1'b0, 1'b0};
    vecs[12] = '{32'h00094883, 32'h0, 32'hF0000000, 4'b1100, 32'h2, 32'hF0000000, 5'd9, 1'b0, 1'b0};
    vecs[13] = '{32'h01095027, 32'h3, 32'h5, 4'b0111, 32'h3, 32'h5, 5'd10, 1'b0, 1'b0};
    vecs[14] = '{32'h01095001, 32'h3, 32'h5, 4'b0001, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // Back-to-back table vectors with the consumer always ready.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (i > 0) chk_vec(i - 1);
      chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; instr = vecs[i].instr; rs_data = vecs[i].rs; rt_data = vecs[i].rt;
    end
    @(negedge clk);
    chk_vec(NV - 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: three bundles against a 3-cycle stall, then in-order drain.
    out_ready = 1'b0; in_valid = 1'b1; instr = addiu_i(5'd1);
    @(negedge clk);
    chk("bp1 wb", {27'd0, wb_addr}, 32'd1);
    chk("bp1 in_ready", {31'd0, in_ready}, 32'd1);
    instr = addiu_i(5'd2);
    @(negedge clk);
    chk("bp2 in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp2 wb held", {27'd0, wb_addr}, 32'd1);
    instr = addiu_i(5'd3);
    @(negedge clk);
    chk("bp3 in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp3 wb held", {27'd0, wb_addr}, 32'd1);
    chk("bp3 opr2 held", opr2, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp4 valid", {31'd0, out_valid}, 32'd1);
    chk("bp4 wb", {27'd0, wb_addr}, 32'd2);
    @(negedge clk);
    chk("bp5 valid", {31'd0, out_valid}, 32'd1);
    chk("bp5 wb", {27'd0, wb_addr}, 32'd3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp6 valid", {31'd0, out_valid}, 32'd0);

    // Flush with skid full and a same-cycle input: everything dropped.
    out_ready = 1'b0; in_valid = 1'b1; instr = addiu_i(5'd4);
    @(negedge clk);
    instr = addiu_i(5'd5);
    @(negedge clk);
    chk("fl skid full", {31'd0, in_ready}, 32'd0);
    instr = addiu_i(5'd6); flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl dropped", {31'd0, out_valid}, 32'd0);

    // Reset asserted mid-stall clears outputs without waiting for a clock.
    out_ready = 1'b0; in_valid = 1'b1;
    instr = vecs[0].instr; rs_data = vecs[0].rs; rt_data = vecs[0].rt;
    @(negedge clk);
    instr = vecs[1].instr; rt_data = vecs[1].rt;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rs pre wb", {27'd0, wb_addr}, 32'd8);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rs out_valid", {31'd0, out_valid}, 32'd0);
    chk("rs in_ready", {31'd0, in_ready}, 32'd1);
    chk("rs alu_control", {28'd0, alu_control}, 32'd0);
    chk("rs opr1", opr1, 32'd0);
    chk("rs opr2", opr2, 32'd0);
    chk("rs wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("rs ovf_check", {31'd0, ovf_check}, 32'd0);
    chk("rs illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rs stays empty", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
